// File: rtl/xcvr_reset_responder.sv
// Transceiver reset/calibration responder: fixed-latency reset acknowledgements, CAL -> PLL_WAIT -> READY sequence, CDR lock model.
// Optional macro XCVR_RESPONDER_RECAL_EN adds recal_req to restart calibration.
module xcvr_reset_responder #(
  parameter int CAL_CYCLES      = 64,
  parameter int PLL_LOCK_CYCLES = 32,
  parameter int STAT_DELAY      = 4,
  parameter int CDR_LOCK_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tx_analogreset,
  input  logic tx_digitalreset,
  input  logic rx_analogreset,
  input  logic rx_digitalreset,
  output logic tx_analogreset_stat,
  output logic tx_digitalreset_stat,
  output logic rx_analogreset_stat,
  output logic rx_digitalreset_stat,
  output logic pll_locked,
  output logic tx_cal_busy,
  output logic rx_cal_busy,
  output logic rx_is_lockedtodata
`ifdef XCVR_RESPONDER_RECAL_EN
  ,
  input  logic recal_req
`endif
);

  localparam logic [1:0] ST_CAL      = 2'd0;
  localparam logic [1:0] ST_PLL_WAIT = 2'd1;
  localparam logic [1:0] ST_READY    = 2'd2;

  localparam int SEQ_MAX = (CAL_CYCLES > PLL_LOCK_CYCLES) ? CAL_CYCLES : PLL_LOCK_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int CDR_W   = $clog2(CDR_LOCK_CYCLES + 1);

  localparam logic [SEQ_W-1:0] CAL_LAST = SEQ_W'(CAL_CYCLES - 1);
  localparam logic [SEQ_W-1:0] PLL_LAST = SEQ_W'(PLL_LOCK_CYCLES - 1);
  localparam logic [CDR_W-1:0] CDR_FULL = CDR_W'(CDR_LOCK_CYCLES);
  localparam logic [CDR_W-1:0] CDR_LAST = CDR_W'(CDR_LOCK_CYCLES - 1);

  logic             recal;
  logic [1:0]       rst_sync;
  logic             run;
  logic [1:0]       state;
  logic [SEQ_W-1:0] seq_cnt;
  logic [3:0]       req;
  logic [3:0]       dly [STAT_DELAY];
  logic [CDR_W-1:0] cdr_cnt;
  logic             cdr_qual;

`ifdef XCVR_RESPONDER_RECAL_EN
  assign recal = recal_req;
`else
  assign recal = 1'b0;
`endif

  // Reset asserts asynchronously but the sequencer only starts two edges after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_CAL;
      seq_cnt <= '0;
    end else if (!run || recal) begin
      state   <= ST_CAL;
      seq_cnt <= '0;
    end else begin
      case (state)
        ST_CAL: begin
          if (seq_cnt == CAL_LAST) begin
            state   <= ST_PLL_WAIT;
            seq_cnt <= '0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        ST_PLL_WAIT: begin
          if (seq_cnt == PLL_LAST) begin
            state   <= ST_READY;
            seq_cnt <= '0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        ST_READY: seq_cnt <= '0;
        default: begin
          state   <= ST_CAL;
          seq_cnt <= '0;
        end
      endcase
    end
  end

  assign tx_cal_busy = (state == ST_CAL);
  assign rx_cal_busy = (state == ST_CAL);
  assign pll_locked  = (state == ST_READY);

  // One shift register per lane, all stepped together; filled with 1 so acks read "in reset".
  assign req = {tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < STAT_DELAY; k++) dly[k] <= '1;
    end else begin
      dly[0] <= req;
      for (int unsigned k = 1; k < STAT_DELAY; k++) dly[k] <= dly[k-1];
    end
  end

  assign tx_analogreset_stat  = dly[STAT_DELAY-1][3];
  assign tx_digitalreset_stat = dly[STAT_DELAY-1][2];
  assign rx_analogreset_stat  = dly[STAT_DELAY-1][1];
  assign rx_digitalreset_stat = dly[STAT_DELAY-1][0];

  // Recal drops pll_locked on the same edge, so lock must be lost on that edge too.
  assign cdr_qual = pll_locked && !rx_analogreset_stat && !rx_cal_busy && !recal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdr_cnt            <= '0;
      rx_is_lockedtodata <= 1'b0;
    end else if (!cdr_qual) begin
      cdr_cnt            <= '0;
      rx_is_lockedtodata <= 1'b0;
    end else begin
      if (cdr_cnt != CDR_FULL) cdr_cnt <= cdr_cnt + 1'b1;
      if (cdr_cnt >= CDR_LAST) rx_is_lockedtodata <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xcvr_reset_responder.sv
// Directed bench for xcvr_reset_responder with default parameters; recal steps build only with XCVR_RESPONDER_RECAL_EN.
module tb_xcvr_reset_responder;

  logic clock = 1'b0;
  logic reset_n;
  logic tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset;
  logic tx_analogreset_stat, tx_digitalreset_stat, rx_analogreset_stat, rx_digitalreset_stat;
  logic pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata;
`ifdef XCVR_RESPONDER_RECAL_EN
  logic recal_req;
`endif

  int checks = 0;
  int errors = 0;

  xcvr_reset_responder dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .tx_analogreset       (tx_analogreset),
    .tx_digitalreset      (tx_digitalreset),
    .rx_analogreset       (rx_analogreset),
    .rx_digitalreset      (rx_digitalreset),
    .tx_analogreset_stat  (tx_analogreset_stat),
    .tx_digitalreset_stat (tx_digitalreset_stat),
    .rx_analogreset_stat  (rx_analogreset_stat),
    .rx_digitalreset_stat (rx_digitalreset_stat),
    .pll_locked           (pll_locked),
    .tx_cal_busy          (tx_cal_busy),
    .rx_cal_busy          (rx_cal_busy),
    .rx_is_lockedtodata   (rx_is_lockedtodata)
`ifdef XCVR_RESPONDER_RECAL_EN
    ,
    .recal_req            (recal_req)
`endif
  );

  always #5 clock = ~clock;

  logic [3:0] stats;
  assign stats = {tx_analogreset_stat, tx_digitalreset_stat, rx_analogreset_stat, rx_digitalreset_stat};

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata packed for compact checks
  function automatic logic [7:0] core();
    return {4'b0, pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata};
  endfunction

  initial begin
    reset_n = 1'b0;
    {tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset} = 4'b1111;
`ifdef XCVR_RESPONDER_RECAL_EN
    recal_req = 1'b0;
`endif
    tick(3);
    check("reset_stats", {4'b0, stats}, 8'h0F);
    check("reset_core", core(), 8'b0110);

    // Release: cal_busy falls on edge 66, pll_locked rises on edge 98
    reset_n = 1'b1;
    tick(65);
    check("cal_busy_edge65", core(), 8'b0110);
    tick(1);
    check("cal_done_edge66", core(), 8'b0000);
    tick(31);
    check("pll_wait_edge97", core(), 8'b0000);
    tick(1);
    check("pll_locked_edge98", core(), 8'b1000);

    // Deassert tx_analogreset: ack falls 4 edges later, others stay 1
    tx_analogreset = 1'b0;
    tick(3);
    check("tx_an_stat_plus3", {4'b0, stats}, 8'h0F);
    tick(1);
    check("tx_an_stat_plus4", {4'b0, stats}, 8'h07);

    // 2-cycle rx_digitalreset pulse
    rx_digitalreset = 1'b0;
    tick(2);
    rx_digitalreset = 1'b1;
    tick(1);
    check("rx_dig_pulse_plus3", {7'b0, rx_digitalreset_stat}, 8'h1);
    tick(1);
    check("rx_dig_pulse_plus4", {7'b0, rx_digitalreset_stat}, 8'h0);
    tick(1);
    check("rx_dig_pulse_plus5", {7'b0, rx_digitalreset_stat}, 8'h0);
    tick(1);
    check("rx_dig_pulse_plus6", {7'b0, rx_digitalreset_stat}, 8'h1);

    // 1-cycle tx_digitalreset pulse, shorter than the delay
    tx_digitalreset = 1'b0;
    tick(1);
    tx_digitalreset = 1'b1;
    tick(2);
    check("tx_dig_pulse_plus3", {7'b0, tx_digitalreset_stat}, 8'h1);
    tick(1);
    check("tx_dig_pulse_plus4", {7'b0, tx_digitalreset_stat}, 8'h0);
    tick(1);
    check("tx_dig_pulse_plus5", {7'b0, tx_digitalreset_stat}, 8'h1);

    // CDR lock: 4 delay + 16 qualified cycles
    rx_analogreset = 1'b0;
    tick(19);
    check("cdr_plus19", core(), 8'b1000);
    tick(1);
    check("cdr_plus20", core(), 8'b1001);

    // rx_digitalreset must not disturb lock
    rx_digitalreset = 1'b0;
    tick(8);
    check("cdr_rx_dig_low", {rx_digitalreset_stat, rx_is_lockedtodata}, 8'b01);
    rx_digitalreset = 1'b1;
    tick(6);
    check("cdr_rx_dig_back", {rx_digitalreset_stat, rx_is_lockedtodata}, 8'b11);

    // Re-assert rx_analogreset: lock drops one edge after its ack rises
    rx_analogreset = 1'b1;
    tick(4);
    check("rx_an_ack_plus4", {rx_analogreset_stat, rx_is_lockedtodata}, 8'b11);
    tick(1);
    check("cdr_drop_plus5", {rx_analogreset_stat, rx_is_lockedtodata}, 8'b10);

    // Restart, then reset mid-PLL_WAIT
    @(posedge clock);
    #3 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick(76);
    check("pll_wait_again", core(), 8'b0000);
    check("tx_an_stat_low", {7'b0, tx_analogreset_stat}, 8'h0);
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_core", core(), 8'b0110);
    check("async_reset_stats", {4'b0, stats}, 8'h0F);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick(65);
    check("rerun_cal_edge65", core(), 8'b0110);
    tick(1);
    check("rerun_cal_edge66", core(), 8'b0000);
    tick(31);
    check("rerun_pll_edge97", core(), 8'b0000);
    tick(1);
    check("rerun_pll_edge98", core(), 8'b1000);

`ifdef XCVR_RESPONDER_RECAL_EN
    rx_analogreset = 1'b0;
    tick(25);
    check("recal_pre_lock", core(), 8'b1001);
    recal_req = 1'b1;
    tick(1);
    recal_req = 1'b0;
    check("recal_next_edge", core(), 8'b0110);
    tick(63);
    check("recal_cal_plus64", core(), 8'b0110);
    tick(1);
    check("recal_cal_done", core(), 8'b0000);
    tick(31);
    check("recal_pll_wait", core(), 8'b0000);
    tick(1);
    check("recal_pll_back", {7'b0, pll_locked}, 8'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xcvr_reset_responder.md
XCVR_RESET_RESPONDER -- requirements
Module: xcvr_reset_responder

Interface
REQ-001 SHALL provide parameter CAL_CYCLES, default 64: cycles tx_cal_busy/rx_cal_busy stay high after reset release.
REQ-002 SHALL provide parameter PLL_LOCK_CYCLES, default 32: cycles from end of calibration to pll_locked assertion.
REQ-003 SHALL provide parameter STAT_DELAY, default 4 (range 1..15): cycles from a reset-request edge to the matching *_stat edge.
REQ-004 SHALL provide parameter CDR_LOCK_CYCLES, default 16: cycles of qualified RX conditions before rx_is_lockedtodata asserts.
REQ-005 Ports: clock  in  1  single clock, all logic rising-edge.
REQ-006 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-007 Ports: tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset  in  1 each  reset requests from the reset controller.
REQ-008 Ports: tx_analogreset_stat, tx_digitalreset_stat, rx_analogreset_stat, rx_digitalreset_stat  out  1 each  delayed reset acknowledgements.
REQ-009 Ports: pll_locked  out  1; tx_cal_busy, rx_cal_busy  out  1 each; rx_is_lockedtodata  out  1.

Function
REQ-010 SHALL implement a three-state machine: CAL -> PLL_WAIT -> READY.
REQ-011 CAL: tx_cal_busy=rx_cal_busy=1 and pll_locked=0; after exactly CAL_CYCLES cycles go to PLL_WAIT and drop both cal_busy outputs.
REQ-012 PLL_WAIT: pll_locked=0; after exactly PLL_LOCK_CYCLES cycles go to READY.
REQ-013 READY: pll_locked=1; remain in READY until reset (or recal, REQ-024).
REQ-014 Each *_stat SHALL equal its request input delayed by exactly STAT_DELAY cycles, independent of FSM state; one independent delay line per lane.
REQ-015 Request pulses shorter than STAT_DELAY SHALL still reproduce on *_stat with identical width and STAT_DELAY latency.
REQ-016 CDR counter SHALL count while pll_locked=1 and rx_analogreset_stat=0 and rx_cal_busy=0; on reaching CDR_LOCK_CYCLES rx_is_lockedtodata=1 and counter saturates.
REQ-017 Any cycle with a qualifying condition false SHALL clear the CDR counter and rx_is_lockedtodata on the next edge.
REQ-018 rx_digitalreset/rx_digitalreset_stat SHALL NOT affect rx_is_lockedtodata.
REQ-019 Counters SHALL be sized clog2(param+1) and never wrap.
REQ-020 Simultaneous assert/deassert across lanes SHALL be handled independently with no inter-lane priority.

Reset
REQ-021 While reset_n=0: FSM=CAL with counter cleared; all four *_stat=1, delay lines filled with 1; pll_locked=0, rx_is_lockedtodata=0, tx_cal_busy=rx_cal_busy=1.
REQ-022 Reset assertion mid-operation SHALL take effect asynchronously in the same instant; release SHALL be synchronously deasserted internally via a two-flop synchronizer, CAL count starting on the first post-sync cycle.

Configuration
REQ-023 Macro XCVR_RESPONDER_RECAL_EN SHALL compile in input port recal_req (1 bit).
REQ-024 With macro: a cycle with recal_req=1 in PLL_WAIT or READY SHALL return FSM to CAL with counters cleared, re-assert both cal_busy and drop pll_locked next edge; recal_req in CAL SHALL restart the CAL count. Without macro: port absent, FSM leaves READY only on reset_n.

Verification
REQ-025 Release reset_n with defaults -> cal_busy falls 64 cycles (+2 sync) after release, pll_locked rises 32 cycles later.
REQ-026 Hold all requests 1, deassert tx_analogreset at cycle T -> tx_analogreset_stat falls at T+4; other stats stay 1.
REQ-027 2-cycle pulse on rx_digitalreset after READY -> rx_digitalreset_stat shows 2-cycle pulse delayed 4 cycles.
REQ-028 In READY, drop rx_analogreset -> rx_is_lockedtodata rises 4+16 cycles later; re-assert rx_analogreset -> falls 1 cycle after rx_analogreset_stat rises.
REQ-029 Assert reset_n=0 mid-PLL_WAIT -> outputs take REQ-021 values immediately, full sequence repeats after release.
REQ-030 With XCVR_RESPONDER_RECAL_EN, recal_req=1 for 1 cycle in READY -> pll_locked=0, rx_is_lockedtodata=0, cal_busy=1 next edge; pll_locked returns after 64+32 cycles.
